// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register-index constants
// and the bundle of pipe-register control strobes.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_IMISS = 3'd1,
    ST_DMISS = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_ex_freeze;
    logic id_ex_flush;
    logic ex_mem_freeze;
    logic icache_abort;
    logic done;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '0;
  // Back end stalled on the D-cache; MEM_WB keeps moving and takes a bubble.
  localparam pipe_ctrl_t CTRL_DMISS = '{pc_freeze: 1'b1, if_id_freeze: 1'b1, id_ex_freeze: 1'b1,
                                        ex_mem_freeze: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_freeze: 1'b1, if_id_freeze: 1'b1, id_ex_flush: 1'b1,
                                           default: 1'b0};
  localparam pipe_ctrl_t CTRL_BRANCH = '{if_id_flush: 1'b1, default: 1'b0};
  // Front end starved (I-miss or halt drain): hold PC, feed bubbles into ID.
  localparam pipe_ctrl_t CTRL_SQUASH = '{pc_freeze: 1'b1, if_id_flush: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_DONE = '{pc_freeze: 1'b1, if_id_freeze: 1'b1, id_ex_freeze: 1'b1,
                                       ex_mem_freeze: 1'b1, done: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_load_use_det.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
module hazard_load_use_det
  import hazard_ctrl_pkg::*;
(
  input  logic             memtoreg,
  input  logic [REG_W-1:0] dst_reg,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             use_src2,
  output logic             load_use_c
);

  // R0 is hard-wired zero, so a load into it never creates a dependency.
  assign load_use_c = memtoreg && (dst_reg != REG_ZERO) &&
                      ((use_src1 && (src1 == dst_reg)) || (use_src2 && (src2 == dst_reg)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipe-register freeze/flush generator: load-use, branch, I/D-cache miss and halt drain.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             branch_taken,
  input  logic             halt_id,
  input  logic             halt_wb,
  input  logic             id_ex_memtoreg,
  input  logic [REG_W-1:0] id_ex_dstreg,
  input  logic [REG_W-1:0] if_id_src1,
  input  logic [REG_W-1:0] if_id_src2,
  input  logic             use_src1,
  input  logic             use_src2,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_freeze,
  output logic             id_ex_flush,
  output logic             ex_mem_freeze,
  output logic             icache_abort,
  output logic             done,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e     state, state_nxt;
  logic       halt_pend, halt_pend_nxt;
  pipe_ctrl_t ctrl;
  logic       load_use_c;

  hazard_load_use_det u_load_use_det (
    .memtoreg   (id_ex_memtoreg),
    .dst_reg    (id_ex_dstreg),
    .src1       (if_id_src1),
    .src2       (if_id_src2),
    .use_src1   (use_src1),
    .use_src2   (use_src2),
    .load_use_c (load_use_c)
  );

  // State register; halt_pend remembers an accepted HLT across a D-miss detour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      halt_pend <= halt_pend_nxt;
    end
  end

  // Next state and zero-latency strobes, highest-priority hazard first.
  always_comb begin
    ctrl          = CTRL_IDLE;
    state_nxt     = state;
    halt_pend_nxt = halt_pend;
    if (rst) begin
      state_nxt = ST_RUN;
    end else if (state == ST_DONE) begin
      ctrl = CTRL_DONE;
    end else if (dcache_miss) begin
      ctrl      = CTRL_DMISS;
      state_nxt = ST_DMISS;
    end else if (halt_pend) begin
      ctrl = CTRL_SQUASH;
      if (halt_wb) begin
        state_nxt = ST_DONE;
      end else if ((state != ST_DRAIN) && icache_miss) begin
        state_nxt = ST_IMISS;
      end else begin
        state_nxt = ST_DRAIN;
      end
    end else if (load_use_c) begin
      ctrl      = CTRL_LOAD_USE;
      state_nxt = ((state == ST_RUN) || !icache_miss) ? ST_RUN : ST_IMISS;
    end else if (branch_taken) begin
      ctrl              = CTRL_BRANCH;
      ctrl.icache_abort = (state == ST_IMISS);
      state_nxt         = ST_RUN;
    end else if (icache_miss) begin
      ctrl      = CTRL_SQUASH;
      state_nxt = ST_IMISS;
    end else if (halt_id) begin
      state_nxt     = ST_DRAIN;
      halt_pend_nxt = 1'b1;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  assign pc_freeze     = ctrl.pc_freeze;
  assign if_id_freeze  = ctrl.if_id_freeze;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_freeze  = ctrl.id_ex_freeze;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_freeze = ctrl.ex_mem_freeze;
  assign icache_abort  = ctrl.icache_abort;
  assign done          = ctrl.done;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of hazard stalls; halt drain and DONE are not stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ctrl.pc_freeze && (state inside {ST_RUN, ST_IMISS, ST_DMISS}) &&
                 (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected strobes,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, icache_abort, done}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] DM   = 8'b1101_0100;
  localparam logic [7:0] IM   = 8'b1010_0000;
  localparam logic [7:0] BR   = 8'b0010_0000;
  localparam logic [7:0] BRA  = 8'b0010_0010;
  localparam logic [7:0] DN   = 8'b1101_0101;

  logic             clk = 1'b0;
  logic             rst;
  logic             icache_miss, dcache_miss, branch_taken, halt_id, halt_wb;
  logic             id_ex_memtoreg, use_src1, use_src2;
  logic [3:0]       id_ex_dstreg, if_id_src1, if_id_src2;
  logic             pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush;
  logic             ex_mem_freeze, icache_abort, done;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0]       act;

  typedef struct {
    logic [7:0]       o;
    logic [CNT_W-1:0] s;
    bit               chk_s;
    string            nm;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_miss    (icache_miss),
    .dcache_miss    (dcache_miss),
    .branch_taken   (branch_taken),
    .halt_id        (halt_id),
    .halt_wb        (halt_wb),
    .id_ex_memtoreg (id_ex_memtoreg),
    .id_ex_dstreg   (id_ex_dstreg),
    .if_id_src1     (if_id_src1),
    .if_id_src2     (if_id_src2),
    .use_src1       (use_src1),
    .use_src2       (use_src2),
    .pc_freeze      (pc_freeze),
    .if_id_freeze   (if_id_freeze),
    .if_id_flush    (if_id_flush),
    .id_ex_freeze   (id_ex_freeze),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_freeze  (ex_mem_freeze),
    .icache_abort   (icache_abort),
    .done           (done),
    .stall_cycles   (stall_cycles)
  );

  assign act = {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
                ex_mem_freeze, icache_abort, done};

  task automatic clr_in();
    icache_miss = 1'b0; dcache_miss = 1'b0; branch_taken = 1'b0;
    halt_id = 1'b0; halt_wb = 1'b0; id_ex_memtoreg = 1'b0;
    id_ex_dstreg = 4'h0; if_id_src1 = 4'h0; if_id_src2 = 4'h0;
    use_src1 = 1'b0; use_src2 = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] dst, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2);
    id_ex_memtoreg = 1'b1; id_ex_dstreg = dst;
    if_id_src1 = s1; use_src1 = u1; if_id_src2 = s2; use_src2 = u2;
  endtask

  // Inputs for this cycle are already applied; cnt marks a cycle the stall counter must count.
  task automatic step(input logic [7:0] exp, input bit cnt, input string nm);
    exp_t e;
    e.o = exp;
    e.s = CNT_EN ? CNT_W'(exp_cnt) : '0;
    e.chk_s = 1'b1;
    e.nm = nm;
    q.push_back(e);
    if (cnt && (exp_cnt < ((1 << CNT_W) - 1))) exp_cnt++;
    @(posedge clk); #1;
  endtask

  // One reset cycle with the current inputs; strobes must read zero while rst is high.
  task automatic do_rst(input string nm);
    exp_t e;
    rst = 1'b1;
    e.o = NONE; e.s = '0; e.chk_s = 1'b0; e.nm = nm;
    q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        checks++;
        if (act !== m.o) begin
          errors++;
          $display("FAIL %s: strobes=%b expected=%b", m.nm, act, m.o);
        end
        if (m.chk_s) begin
          checks++;
          if (stall_cycles !== m.s) begin
            errors++;
            $display("FAIL %s_cnt: stall_cycles=%0d expected=%0d", m.nm, stall_cycles, m.s);
          end
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step(NONE, 0, "reset_idle");
    // Load-use: LDR R3 in EX, ADD reading R3 in ID.
    set_lu(4'd3, 4'd3, 1'b1, 4'd0, 1'b0);  step(LU, 1, "load_use");
    clr_in();                              step(NONE, 0, "lu_release");
    set_lu(4'd0, 4'd0, 1'b1, 4'd0, 1'b1);  step(NONE, 0, "lu_dst_r0");
    set_lu(4'd5, 4'd5, 1'b0, 4'd5, 1'b1);  step(LU, 1, "lu_src2");
    use_src2 = 1'b0;                       step(NONE, 0, "lu_no_use");

    // D-miss held four cycles.
    clr_in(); dcache_miss = 1'b1;
    for (int i = 0; i < 4; i++) step(DM, 1, "dmiss");
    dcache_miss = 1'b0;                    step(NONE, 0, "dmiss_exit");

    // I-miss three cycles with a taken branch on the second.
    icache_miss = 1'b1;                    step(IM, 1, "imiss_1");
    branch_taken = 1'b1;                   step(BRA, 0, "imiss_branch");
    branch_taken = 1'b0;                   step(IM, 1, "imiss_3");
    icache_miss = 1'b0;                    step(NONE, 0, "imiss_end");
    branch_taken = 1'b1;                   step(BR, 0, "branch_run");

    // Overlapping misses, D-cache resolves first.
    clr_in(); dcache_miss = 1'b1; icache_miss = 1'b1;
    step(DM, 1, "dual_d1");
    step(DM, 1, "dual_d2");
    dcache_miss = 1'b0;                    step(IM, 1, "dual_i1");
    step(IM, 1, "dual_i2");
    icache_miss = 1'b0;                    step(NONE, 0, "dual_end");

    // Priority ladder; counter saturates at 15 here when enabled.
    set_lu(4'd3, 4'd3, 1'b1, 4'd0, 1'b0); dcache_miss = 1'b1;
    step(DM, 1, "prio_dmiss_lu");
    dcache_miss = 1'b0;                    step(LU, 1, "prio_lu_after_dmiss");
    branch_taken = 1'b1;                   step(LU, 1, "prio_lu_branch");
    clr_in(); branch_taken = 1'b1; icache_miss = 1'b1;
    step(BR, 0, "prio_branch_imiss");
    clr_in(); halt_id = 1'b1; icache_miss = 1'b1;
    step(IM, 1, "prio_imiss_halt");
    clr_in();                              step(NONE, 0, "imiss_exit_nohalt");
    step(NONE, 0, "halt_not_taken");

    // Reset in the middle of a D-miss.
    dcache_miss = 1'b1;                    step(DM, 1, "dmiss_pre_rst");
    do_rst("rst_in_dmiss");
    dcache_miss = 1'b0;                    step(NONE, 0, "post_rst");

    // Halt drain with a D-miss detour, then DONE held.
    halt_id = 1'b1;                        step(NONE, 0, "halt_accept");
    halt_id = 1'b0;                        step(IM, 0, "drain_1");
    dcache_miss = 1'b1;                    step(DM, 0, "drain_dmiss");
    step(DM, 1, "drain_dmiss_hold");
    dcache_miss = 1'b0;                    step(IM, 1, "drain_resume");
    halt_wb = 1'b1;                        step(IM, 0, "drain_halt_wb");
    halt_wb = 1'b0;                        step(DN, 0, "done");
    dcache_miss = 1'b1; icache_miss = 1'b1; branch_taken = 1'b1;
    set_lu(4'd3, 4'd3, 1'b1, 4'd0, 1'b0);  step(DN, 0, "done_hold");
    clr_in();                              step(DN, 0, "done_hold2");
    do_rst("rst_in_done");
    step(NONE, 0, "done_cleared");

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
